lc3_control: RTL and testbench

Instruction sequencing and decode unit for the LC-3 datapath. A Moore state machine steps each instruction through fetch, decode and execute. It drives every register load, bus gate, mux select and SRAM strobe that the datapath consumes. It sits directly upstream of the datapath, takes opcode and condition feedback from it, and has no datapath state of its own.

---
 rtl/lc3_control.sv | 252 +++++++++++++++++++++++++
 tb/tb_lc3_control.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_control.sv
//============================================================================
// Module      : lc3_control
// Description : LC-3 instruction sequencer. Moore FSM stepping each
//               instruction through fetch, decode and execute, driving the
//               datapath's register loads, bus gates, mux selects and SRAM
//               strobes.
// Revision    : 1.0  initial release
//============================================================================
`default_nettype none

module lc3_control (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_CE,
  output logic       Mem_UB,
  output logic       Mem_LB,
  output logic       Mem_OE,
  output logic       Mem_WE
);

  typedef enum logic [4:0] {
    S_HALTED, S_18, S_33_1, S_33_2, S_35, S_32,
    S_01, S_05, S_09, S_00, S_22, S_12, S_04, S_21,
    S_06, S_25_1, S_25_2, S_27, S_07, S_23, S_16_1, S_16_2,
    S_PAUSE_IR1, S_PAUSE_IR2
  } state_t;

  typedef struct packed {
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_ir;
    logic       ld_ben;
    logic       ld_cc;
    logic       ld_reg;
    logic       ld_pc;
    logic       ld_led;
    logic       gate_pc;
    logic       gate_mdr;
    logic       gate_alu;
    logic       gate_marmux;
    logic [1:0] pcmux;
    logic       drmux;
    logic       sr1mux;
    logic       sr2mux;
    logic       addr1mux;
    logic [1:0] addr2mux;
    logic [1:0] aluk;
    logic       mem_oe;
    logic       mem_we;
  } ctrl_t;

  state_t state;
  state_t state_next;
  ctrl_t  ctrl;

  // Control word presented while sitting in state s. IR bits are stable for
  // the whole execute phase (IR only loads in S_35), so sampling them on
  // entry to the state is equivalent to sampling them during it.
  function automatic ctrl_t ctrl_for(state_t s, logic ir5, logic ir11);
    ctrl_t c;
    c        = '0;
    c.mem_oe = 1'b1;
    c.mem_we = 1'b1;
    case (s)
      S_18: begin
        c.gate_pc = 1'b1;
        c.ld_mar  = 1'b1;
        c.pcmux   = 2'b01;
        c.ld_pc   = 1'b1;
      end
      S_33_1: c.mem_oe = 1'b0;
      S_33_2: begin
        c.mem_oe = 1'b0;
        c.ld_mdr = 1'b1;
      end
      S_35: begin
        c.gate_mdr = 1'b1;
        c.ld_ir    = 1'b1;
      end
      S_32: c.ld_ben = 1'b1;
      S_01, S_05: begin
        c.sr2mux   = ir5;
        c.aluk     = (s == S_05) ? 2'b01 : 2'b00;
        c.gate_alu = 1'b1;
        c.ld_reg   = 1'b1;
        c.ld_cc    = 1'b1;
      end
      S_09: begin
        c.aluk     = 2'b10;
        c.gate_alu = 1'b1;
        c.ld_reg   = 1'b1;
        c.ld_cc    = 1'b1;
      end
      S_22: begin
        c.addr1mux = 1'b0;
        c.addr2mux = 2'b10;
        c.pcmux    = 2'b10;
        c.ld_pc    = 1'b1;
      end
      S_12: begin
        c.addr1mux = 1'b1;
        c.addr2mux = 2'b00;
        c.pcmux    = 2'b10;
        c.ld_pc    = 1'b1;
      end
      S_04: begin
        c.gate_pc = 1'b1;
        c.drmux   = 1'b1;
        c.ld_reg  = 1'b1;
      end
      S_21: begin
        c.addr1mux = ~ir11;
        c.addr2mux = ir11 ? 2'b11 : 2'b00;
        c.pcmux    = 2'b10;
        c.ld_pc    = 1'b1;
      end
      S_06, S_07: begin
        c.addr1mux    = 1'b1;
        c.addr2mux    = 2'b01;
        c.gate_marmux = 1'b1;
        c.ld_mar      = 1'b1;
      end
      S_25_1: c.mem_oe = 1'b0;
      S_25_2: begin
        c.mem_oe = 1'b0;
        c.ld_mdr = 1'b1;
      end
      S_27: begin
        c.gate_mdr = 1'b1;
        c.ld_reg   = 1'b1;
        c.ld_cc    = 1'b1;
      end
      S_23: begin
        c.sr1mux   = 1'b0;
        c.aluk     = 2'b11;
        c.gate_alu = 1'b1;
        c.ld_mdr   = 1'b1;
      end
      S_16_1, S_16_2: c.mem_we = 1'b0;
      S_PAUSE_IR1:    c.ld_led = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  // Next-state selection: fixed fetch chain, opcode dispatch in decode,
  // two-phase handshake on Continue for PAUSE.
  always_comb begin
    state_next = state;
    case (state)
      S_HALTED: if (Run) state_next = S_18;
      S_18:     state_next = S_33_1;
      S_33_1:   state_next = S_33_2;
      S_33_2:   state_next = S_35;
      S_35:     state_next = S_32;
      S_32: begin
        case (Opcode)
          4'b0001: state_next = S_01;
          4'b0101: state_next = S_05;
          4'b1001: state_next = S_09;
          4'b0000: state_next = S_00;
          4'b1100: state_next = S_12;
          4'b0100: state_next = S_04;
          4'b0110: state_next = S_06;
          4'b0111: state_next = S_07;
          4'b1101: state_next = S_PAUSE_IR1;
          default: state_next = S_18;
        endcase
      end
      S_00:        state_next = BEN ? S_22 : S_18;
      S_04:        state_next = S_21;
      S_06:        state_next = S_25_1;
      S_25_1:      state_next = S_25_2;
      S_25_2:      state_next = S_27;
      S_07:        state_next = S_23;
      S_23:        state_next = S_16_1;
      S_16_1:      state_next = S_16_2;
      S_PAUSE_IR1: if (Continue) state_next = S_PAUSE_IR2;
      S_PAUSE_IR2: if (!Continue) state_next = S_18;
      S_01, S_05, S_09, S_22, S_12, S_21, S_27, S_16_2:
                   state_next = S_18;
      default:     state_next = S_HALTED;
    endcase
  end

  // State register with the control word registered alongside it, so every
  // output comes straight from a flop; reset overrides any transition.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_HALTED;
      ctrl  <= ctrl_for(S_HALTED, 1'b0, 1'b0);
    end else begin
      state <= state_next;
      ctrl  <= ctrl_for(state_next, IR_5, IR_11);
    end
  end

  assign LD_MAR     = ctrl.ld_mar;
  assign LD_MDR     = ctrl.ld_mdr;
  assign LD_IR      = ctrl.ld_ir;
  assign LD_BEN     = ctrl.ld_ben;
  assign LD_CC      = ctrl.ld_cc;
  assign LD_REG     = ctrl.ld_reg;
  assign LD_PC      = ctrl.ld_pc;
  assign LD_LED     = ctrl.ld_led;
  assign GatePC     = ctrl.gate_pc;
  assign GateMDR    = ctrl.gate_mdr;
  assign GateALU    = ctrl.gate_alu;
  assign GateMARMUX = ctrl.gate_marmux;
  assign PCMUX      = ctrl.pcmux;
  assign DRMUX      = ctrl.drmux;
  assign SR1MUX     = ctrl.sr1mux;
  assign SR2MUX     = ctrl.sr2mux;
  assign ADDR1MUX   = ctrl.addr1mux;
  assign ADDR2MUX   = ctrl.addr2mux;
  assign ALUK       = ctrl.aluk;
  assign Mem_OE     = ctrl.mem_oe;
  assign Mem_WE     = ctrl.mem_we;

  // SRAM chip enable and byte lanes are permanently active.
  assign Mem_CE = 1'b0;
  assign Mem_UB = 1'b0;
  assign Mem_LB = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_lc3_control.sv
//============================================================================
// Module      : tb_lc3_control
// Description : Scoreboard bench for lc3_control. An instruction-level model
//               expands each issued instruction into its expected per-cycle
//               control words; a monitor pops and compares every cycle.
// Revision    : 1.0  initial release
//============================================================================
`default_nettype none

module tb_lc3_control;

  logic       Clk = 1'b0;
  logic       Reset, Run, Continue;
  logic [3:0] Opcode;
  logic       IR_5, IR_11, BEN;
  logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic       GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
  logic       Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;

  lc3_control dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
    .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
    .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU),
    .GateMARMUX(GateMARMUX), .PCMUX(PCMUX), .DRMUX(DRMUX),
    .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX),
    .ADDR2MUX(ADDR2MUX), .ALUK(ALUK), .Mem_CE(Mem_CE), .Mem_UB(Mem_UB),
    .Mem_LB(Mem_LB), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
  );

  // 10 ns clock
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic       drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] addr2mux;
    logic [1:0] aluk;
    logic       mem_ce, mem_ub, mem_lb, mem_oe, mem_we;
  } outs_t;

  typedef struct {
    outs_t v;
    int    lbl;
  } exp_t;

  localparam int L_HALT = 0,  L_18  = 1,  L_33A = 2,  L_33B = 3,  L_35  = 4;
  localparam int L_32   = 5,  L_01  = 6,  L_05  = 7,  L_09  = 8,  L_00  = 9;
  localparam int L_22   = 10, L_12  = 11, L_04  = 12, L_21  = 13, L_06  = 14;
  localparam int L_25A  = 15, L_25B = 16, L_27  = 17, L_07  = 18, L_23  = 19;
  localparam int L_16A  = 20, L_16B = 21, L_P1  = 22, L_P2  = 23;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  function automatic string lname(int l);
    case (l)
      L_HALT: return "Halted";  L_18:  return "S_18";   L_33A: return "S_33_1";
      L_33B:  return "S_33_2";  L_35:  return "S_35";   L_32:  return "S_32";
      L_01:   return "S_01";    L_05:  return "S_05";   L_09:  return "S_09";
      L_00:   return "S_00";    L_22:  return "S_22";   L_12:  return "S_12";
      L_04:   return "S_04";    L_21:  return "S_21";   L_06:  return "S_06";
      L_25A:  return "S_25_1";  L_25B: return "S_25_2"; L_27:  return "S_27";
      L_07:   return "S_07";    L_23:  return "S_23";   L_16A: return "S_16_1";
      L_16B:  return "S_16_2";  L_P1:  return "PauseIR1";
      default: return "PauseIR2";
    endcase
  endfunction

  // Reference table: control word required in each step of an instruction.
  function automatic outs_t model_outs(int l, logic ir5, logic ir11);
    outs_t o;
    o = '0;
    o.mem_oe = 1'b1;
    o.mem_we = 1'b1;
    case (l)
      L_18:  begin o.gate_pc = 1; o.ld_mar = 1; o.pcmux = 2'b01; o.ld_pc = 1; end
      L_33A, L_25A: o.mem_oe = 0;
      L_33B, L_25B: begin o.mem_oe = 0; o.ld_mdr = 1; end
      L_35:  begin o.gate_mdr = 1; o.ld_ir = 1; end
      L_32:  o.ld_ben = 1;
      L_01:  begin o.sr2mux = ir5; o.gate_alu = 1; o.ld_reg = 1; o.ld_cc = 1; end
      L_05:  begin o.sr2mux = ir5; o.aluk = 2'b01; o.gate_alu = 1; o.ld_reg = 1; o.ld_cc = 1; end
      L_09:  begin o.aluk = 2'b10; o.gate_alu = 1; o.ld_reg = 1; o.ld_cc = 1; end
      L_22:  begin o.addr2mux = 2'b10; o.pcmux = 2'b10; o.ld_pc = 1; end
      L_12:  begin o.addr1mux = 1; o.pcmux = 2'b10; o.ld_pc = 1; end
      L_04:  begin o.gate_pc = 1; o.drmux = 1; o.ld_reg = 1; end
      L_21:  begin
        if (ir11) o.addr2mux = 2'b11;
        else      o.addr1mux = 1;
        o.pcmux = 2'b10;
        o.ld_pc = 1;
      end
      L_06, L_07: begin o.addr1mux = 1; o.addr2mux = 2'b01; o.gate_marmux = 1; o.ld_mar = 1; end
      L_27:  begin o.gate_mdr = 1; o.ld_reg = 1; o.ld_cc = 1; end
      L_23:  begin o.aluk = 2'b11; o.gate_alu = 1; o.ld_mdr = 1; end
      L_16A, L_16B: o.mem_we = 0;
      L_P1:  o.ld_led = 1;
      default: ;
    endcase
    return o;
  endfunction

  function automatic outs_t dut_outs();
    return {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
            GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX,
            SR2MUX, ADDR1MUX, ADDR2MUX, ALUK, Mem_CE, Mem_UB, Mem_LB,
            Mem_OE, Mem_WE};
  endfunction

  // Monitor: one control word is presented per cycle; compare mid-cycle.
  always @(negedge Clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks++;
      if (dut_outs() !== mon_e.v) begin
        errors++;
        $display("FAIL %s @%0t: got %h required %h", lname(mon_e.lbl),
                 $time, dut_outs(), mon_e.v);
      end
    end
  end

  task automatic cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_step(int l, logic ir5, logic ir11);
    exp_t e;
    e.v   = model_outs(l, ir5, ir11);
    e.lbl = l;
    sb.push_back(e);
  endtask

  // Sit in Halted for n cycles, then raise Run so the next edge starts fetch.
  task automatic idle_halted(int n);
    for (int i = 0; i < n; i++) begin
      Run      = 1'b0;
      Continue = 1'($urandom_range(0, 1));
      cycle();
      expect_step(L_HALT, 1'b0, 1'b0);
    end
    Run      = 1'b1;
    Continue = 1'b0;
  endtask

  // Issue one instruction starting at the next edge (which enters S_18).
  // The model expands it into its step list; abort_at >= 0 asserts Reset
  // during that step index.
  task automatic run_instr(logic [3:0] op, logic ir5, logic ir11, logic ben,
                           int p1, int p2, int abort_at);
    int seq[$];
    int n;
    bit aborted;
    seq = '{L_18, L_33A, L_33B, L_35, L_32};
    case (op)
      4'b0001: seq.push_back(L_01);
      4'b0101: seq.push_back(L_05);
      4'b1001: seq.push_back(L_09);
      4'b0000: begin seq.push_back(L_00); if (ben) seq.push_back(L_22); end
      4'b1100: seq.push_back(L_12);
      4'b0100: begin seq.push_back(L_04); seq.push_back(L_21); end
      4'b0110: begin seq.push_back(L_06); seq.push_back(L_25A);
                     seq.push_back(L_25B); seq.push_back(L_27); end
      4'b0111: begin seq.push_back(L_07); seq.push_back(L_23);
                     seq.push_back(L_16A); seq.push_back(L_16B); end
      4'b1101: begin
        repeat (p1) seq.push_back(L_P1);
        repeat (p2) seq.push_back(L_P2);
      end
      default: ;
    endcase
    n       = seq.size();
    aborted = (abort_at >= 0) && (abort_at < n);
    if (aborted) n = abort_at + 1;

    cycle();
    Opcode = op;
    IR_5   = ir5;
    IR_11  = ir11;
    BEN    = ben;
    for (int i = 0; i < n; i++) expect_step(seq[i], ir5, ir11);

    for (int c = 0; c < n; c++) begin
      if (c > 0) cycle();
      Run = 1'($urandom_range(0, 1));
      if (op == 4'b1101)
        Continue = (c >= 4 + p1) && (c < 4 + p1 + p2);
      else
        Continue = 1'($urandom_range(0, 1));
    end

    if (aborted) begin
      Reset = 1'b1;
      cycle();
      expect_step(L_HALT, 1'b0, 1'b0);
      Reset    = 1'b0;
      Continue = 1'b0;
      idle_halted($urandom_range(1, 3));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset    = 1'b1;
    Run      = 1'b0;
    Continue = 1'b0;
    Opcode   = 4'h0;
    IR_5     = 1'b0;
    IR_11    = 1'b0;
    BEN      = 1'b0;
    cycle();
    expect_step(L_HALT, 1'b0, 1'b0);
    Run = 1'b1;                       // Reset must win over Run
    cycle();
    expect_step(L_HALT, 1'b0, 1'b0);
    Reset = 1'b0;
    idle_halted(3);

    // One of each instruction class, then the boundary cases.
    run_instr(4'b0001, 1'b1, 1'b0, 1'b0, 1, 1, -1);   // ADD imm
    run_instr(4'b0101, 1'b0, 1'b0, 1'b0, 1, 1, -1);   // AND reg
    run_instr(4'b1001, 1'b1, 1'b1, 1'b0, 1, 1, -1);   // NOT
    run_instr(4'b0000, 1'b0, 1'b0, 1'b0, 1, 1, -1);   // BR not taken
    run_instr(4'b0000, 1'b0, 1'b0, 1'b1, 1, 1, -1);   // BR taken
    run_instr(4'b1100, 1'b0, 1'b0, 1'b0, 1, 1, -1);   // JMP
    run_instr(4'b0100, 1'b0, 1'b1, 1'b0, 1, 1, -1);   // JSR
    run_instr(4'b0100, 1'b0, 1'b0, 1'b0, 1, 1, -1);   // JSRR
    run_instr(4'b0110, 1'b0, 1'b0, 1'b0, 1, 1, -1);   // LDR
    run_instr(4'b0111, 1'b0, 1'b0, 1'b0, 1, 1, -1);   // STR
    run_instr(4'b1101, 1'b0, 1'b0, 1'b0, 10, 3, -1);  // PAUSE, long waits
    run_instr(4'b1101, 1'b0, 1'b0, 1'b0, 1, 1, -1);   // PAUSE, single pulse
    run_instr(4'b1111, 1'b1, 1'b1, 1'b1, 1, 1, -1);   // unsupported
    run_instr(4'b0111, 1'b0, 1'b0, 1'b0, 1, 1, 1);    // reset in S_33_1
    run_instr(4'b0111, 1'b0, 1'b0, 1'b0, 1, 1, 7);    // reset in S_16_1
    run_instr(4'b1101, 1'b0, 1'b0, 1'b0, 2, 4, 8);    // reset in PauseIR2

    for (int k = 0; k < 60; k++) begin
      logic [3:0] op;
      int         ab;
      op = 4'($urandom_range(0, 15));
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 14)) : -1;
      run_instr(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(1, 10),
                $urandom_range(1, 4), ab);
    end

    @(negedge Clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
